fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter for a VGA pipeline.
// The display fetch has absolute priority. It reads while blank_b=1.
// Queued pixel writes are drained one per cycle while blanking (blank_b=0).
//
// Ports:
//   vgaclk, reset_n            clock and asynchronous active-low reset
//   blank_b, fb_x, fb_y        display-active flag and fetch coordinates
//   wr_valid/wr_addr/wr_data   write request, accepted when wr_ready=1
//   wr_ready                   write FIFO not full
//   mem_addr/mem_we/mem_wdata  registered command to a synchronous RAM
//   mem_rdata                  RAM read data, valid one cycle after command
//   pix_data/pix_valid         fetched pixel, two cycles after coordinate sample
//   state                      IDLE=0, DISP=1, DRAIN=2
//   stall_cnt                  count of cycles with wr_valid=1 and wr_ready=0
//
// Build option: define FB_ARB_STATS_EN to include the stall counter.
// Without it, stall_cnt is tied to 0.
module fb_arbiter #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int FB_W  = 160,
  parameter int DEPTH = 4
) (
  input  logic          vgaclk,
  input  logic          reset_n,
  input  logic          blank_b,
  input  logic [7:0]    fb_x,
  input  logic [6:0]    fb_y,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic [1:0]    state,
  output logic [15:0]   stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Write FIFO
  logic [AW-1:0] r_fifo_addr [DEPTH];
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_push, w_pop;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wr_ready = !w_full;
  assign w_push   = wr_valid && !w_full;
  // Pop is based on the registered count.
  // A push into an empty FIFO is therefore never popped on the same edge.
  assign w_pop    = !blank_b && !w_empty;

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge vgaclk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // The display address is computed in AW bits.
  // Modulo-2^AW arithmetic gives the same truncated result as a wide product.
  logic [AW-1:0] w_disp_addr;
  assign w_disp_addr = AW'(fb_y) * AW'(FB_W) + AW'(fb_x);

  logic          w_we_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_wdata_nxt;

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = mem_wdata;
    if (blank_b) begin
      w_state_nxt = ST_DISP;
      w_addr_nxt  = w_disp_addr;
    end else if (!w_empty) begin
      w_state_nxt = ST_DRAIN;
      w_we_nxt    = 1'b1;
      w_addr_nxt  = r_fifo_addr[r_rptr];
      w_wdata_nxt = r_fifo_data[r_rptr];
    end
  end

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      mem_we    <= w_we_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
    end
  end

  assign state = r_state;

  // Pixel return path.
  // The edge sampling blank_b issues the command, the next edge is the RAM read,
  // and the following edge captures the pixel.
  // blank_b therefore goes through two stages before reaching pix_valid.
  logic r_blank_d1, r_blank_d2;

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_d1 <= 1'b0;
      r_blank_d2 <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      r_blank_d1 <= blank_b;
      r_blank_d2 <= r_blank_d1;
      pix_valid  <= r_blank_d2;
      pix_data   <= r_blank_d2 ? mem_rdata : '0;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (wr_valid && w_full && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int FB_W  = 160;
  localparam int DEPTH = 4;

  logic          vgaclk = 1'b0;
  logic          reset_n;
  logic          blank_b;
  logic [7:0]    fb_x;
  logic [6:0]    fb_y;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic [1:0]    state;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW-1:0] exp_wr [$];
  logic [DW-1:0]    exp_pix [$];

  logic [DW-1:0] ram [2**AW];

  fb_arbiter #(.AW(AW), .DW(DW), .FB_W(FB_W), .DEPTH(DEPTH)) dut (
    .vgaclk    (vgaclk),
    .reset_n   (reset_n),
    .blank_b   (blank_b),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .state     (state),
    .stall_cnt (stall_cnt)
  );

  always #5 vgaclk = ~vgaclk;

  // Synchronous RAM, read-first. Contents start as addr[7:0] ^ 8'h5A.
  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = 8'(i) ^ 8'h5A;
    mem_rdata = '0;
  end

  always @(posedge vgaclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write or a pixel.
  initial begin
    logic [AW+DW-1:0] e;
    logic [DW-1:0]    p;
    forever begin
      @(negedge vgaclk);
      if (reset_n && mem_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
          check("wr_data", 32'(mem_wdata), 32'(e[DW-1:0]));
        end
      end
      if (reset_n && pix_valid) begin
        if (exp_pix.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
        end else begin
          p = exp_pix.pop_front();
          check("pix_data", 32'(pix_data), 32'(p));
        end
      end else if (reset_n) begin
        check("pix_zero", 32'(pix_data), 32'h0);
      end
    end
  end

  // One cycle: drive inputs just after an edge, then wait for the next edge plus 1.
  task automatic cyc(input logic b, input logic [7:0] x, input logic [6:0] y,
                     input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic acc, input logic [DW-1:0] px);
    blank_b  = b;
    fb_x     = x;
    fb_y     = y;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    if (b) exp_pix.push_back(px);
    if (v && acc) exp_wr.push_back({a, d});
    @(posedge vgaclk);
    #1;
    if (b) check("no_we_disp", 32'(mem_we), 32'h0);
  endtask

  task automatic blank();
    cyc(1'b0, 8'd0, 7'd0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    reset_n  = 1'b0;
    blank_b  = 1'b0;
    fb_x     = '0;
    fb_y     = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (3) @(posedge vgaclk);
    #1;
    check("rst_we",    32'(mem_we),    32'h0);
    check("rst_addr",  32'(mem_addr),  32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_pixv",  32'(pix_valid), 32'h0);
    check("rst_pixd",  32'(pix_data),  32'h0);
    check("rst_state", 32'(state),     32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    check("rst_ready", 32'(wr_ready),  32'h1);
    reset_n = 1'b1;

    // Fetch (5,2) -> address 325. Command on the first edge, pixel two edges later.
    cyc(1'b1, 8'd5, 7'd2, 1'b0, '0, '0, 1'b0, 8'h1F);
    check("disp_addr",  32'(mem_addr),  32'd325);
    check("disp_state", 32'(state),     32'd1);
    cyc(1'b1, 8'd0, 7'd0, 1'b0, '0, '0, 1'b0, 8'h5A);
    check("pixv_lat1",  32'(pix_valid), 32'h0);
    check("disp_addr0", 32'(mem_addr),  32'd0);
    cyc(1'b1, 8'd159, 7'd1, 1'b0, '0, '0, 1'b0, 8'h65);
    check("pixv_lat2",  32'(pix_valid), 32'h1);
    check("pix_325",    32'(pix_data),  32'h1F);
    check("disp_addr319", 32'(mem_addr), 32'd319);
    cyc(1'b1, 8'd255, 7'd127, 1'b0, '0, '0, 1'b0, 8'h05);
    check("disp_addr_max", 32'(mem_addr), 32'd20575);

    // Fill the FIFO during display.
    for (int i = 0; i < 4; i++) begin
      check("ready_fill", 32'(wr_ready), 32'h1);
      cyc(1'b1, 8'd10, 7'd100, 1'b1, AW'(15'h7000 + i), DW'(8'hA0 + i), 1'b1, 8'hD0);
    end
    check("ready_full", 32'(wr_ready), 32'h0);

    // Hold a write against a full FIFO for 10 cycles.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 8'd10, 7'd100, 1'b1, 15'h7100, 8'hEE, 1'b0, 8'hD0);
`ifdef FB_ARB_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'd10);
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Blanking drains A0..A3 on consecutive cycles, then the FSM goes idle.
    for (int i = 0; i < 4; i++) begin
      blank();
      check("drain_we",    32'(mem_we), 32'h1);
      check("drain_state", 32'(state),  32'd2);
    end
    blank();
    check("idle_state", 32'(state),    32'd0);
    check("idle_we",    32'(mem_we),   32'h0);
    check("idle_hold",  32'(mem_addr), 32'h7003);

    // Two entries held, then a push and a pop land on the same edge.
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7200, 8'hB0, 1'b1, 8'h5A);
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7201, 8'hB1, 1'b1, 8'h5A);
    cyc(1'b0, 8'd0, 7'd0, 1'b1, 15'h7202, 8'hB2, 1'b1, 8'h00);
    check("pp_we", 32'(mem_we), 32'h1);
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7203, 8'hB3, 1'b1, 8'h5A);
    check("pp_ready3", 32'(wr_ready), 32'h1);
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7204, 8'hB4, 1'b1, 8'h5A);
    check("pp_ready4", 32'(wr_ready), 32'h0);
    repeat (5) blank();

    // Display resumes while one entry is still queued.
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7300, 8'hC0, 1'b1, 8'h5A);
    cyc(1'b1, 8'd0, 7'd0, 1'b1, 15'h7301, 8'hC1, 1'b1, 8'h5A);
    blank();
    check("c0_we", 32'(mem_we), 32'h1);
    cyc(1'b1, 8'd5, 7'd2, 1'b0, '0, '0, 1'b0, 8'h1F);
    check("c1_read_addr", 32'(mem_addr), 32'd325);
    cyc(1'b1, 8'd5, 7'd2, 1'b0, '0, '0, 1'b0, 8'h1F);
    blank();
    check("c1_we",    32'(mem_we),    32'h1);
    check("c1_addr",  32'(mem_addr),  32'h7301);
    check("c1_wdata", 32'(mem_wdata), 32'hC1);
    repeat (3) blank();

    // Reset while draining with three entries left.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'd0, 7'd0, 1'b1, AW'(15'h7400 + i), DW'(8'hD0 + i), 1'b1, 8'h5A);
    blank();
    check("d_state", 32'(state),  32'd2);
    check("d_we",    32'(mem_we), 32'h1);
    @(negedge vgaclk);
    #1;
    check("d_pending", 32'(exp_wr.size()), 32'd3);
    reset_n = 1'b0;
    #1;
    check("arst_we",    32'(mem_we),    32'h0);
    check("arst_ready", 32'(wr_ready),  32'h1);
    check("arst_state", 32'(state),     32'd0);
    check("arst_pixv",  32'(pix_valid), 32'h0);
    // Reset discards pending writes and in-flight pixels.
    exp_wr.delete();
    exp_pix.delete();
    @(posedge vgaclk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      blank();
      check("post_rst_we",    32'(mem_we),   32'h0);
      check("post_rst_ready", 32'(wr_ready), 32'h1);
    end

    repeat (3) blank();
    check("wr_queue_empty",  32'(exp_wr.size()),  32'd0);
    check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
